// File: rtl/parity_frame_checker_pkg.sv
// Shared types and helpers for the streaming row/column parity frame checker.
package parity_pkg;

  typedef enum logic {
    S_DATA  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  // Word counter width; a one-word frame still needs a 1-bit counter.
  function automatic int cnt_width(input int frame_len);
    return (frame_len <= 1) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Valid/ready stream bundle: upstream word + parity in, checked word + flags out.
interface parity_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_parity;
  logic              out_row_err;
  logic              out_col_err;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_parity, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_row_err, out_col_err, out_last
  );

  modport slave (
    input  in_valid, in_data, in_parity, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_row_err, out_col_err, out_last
  );
endinterface

// File: rtl/parity_frame_checker_reduce.sv
// Row parity generator: XOR of all data bits, inverted in odd mode.
module parity_reduce #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  output logic              gen
);

  assign gen = (^data) ^ mode;

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming row-parity and per-frame LRC checker with a single registered output stage
// and a saturating error counter.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   odd_mode,
  input  logic                   abort,
  input  logic                   clr_count,
  parity_frame_checker_if.slave  bus,
  output logic [CNT_W-1:0]       err_count
);

  localparam int CNT_BITS = cnt_width(FRAME_LEN);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(FRAME_LEN - 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [DATA_W-1:0]   col_acc_q;
  logic                mode_q;

  logic accept;
  logic frame_start;
  logic mode_eff;
  logic gen;
  logic row_err;
  logic col_err;
  logic is_check;
  logic last_data;
  logic [CNT_W:0] cnt_sum;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Mode is sampled only on the first word of a frame and held until the LRC.
  assign frame_start = (state_q == S_DATA) && (cnt_q == '0);
  assign mode_eff    = frame_start ? odd_mode : mode_q;

  parity_reduce #(.DATA_W(DATA_W)) u_reduce (
    .data (bus.in_data),
    .mode (mode_eff),
    .gen  (gen)
  );

  assign row_err = (gen != bus.in_parity);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_DATA;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_DATA;
    end else if (accept) begin
      case (state_q)
        S_DATA:  if (cnt_q == LAST_IDX) state_d = S_CHECK;
        S_CHECK: state_d = S_DATA;
        default: state_d = S_DATA;
      endcase
    end
  end

  always_comb begin
    is_check  = (state_q == S_CHECK);
    last_data = (state_q == S_DATA) && (cnt_q == LAST_IDX);
    col_err   = is_check && (bus.in_data != col_acc_q);
  end

  // Abort wins over the accepted word: it still goes out, but the new frame starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      col_acc_q <= '0;
      mode_q    <= MODE_EVEN;
    end else if (abort) begin
      cnt_q     <= '0;
      col_acc_q <= '0;
      mode_q    <= MODE_EVEN;
    end else if (accept) begin
      if (is_check) begin
        cnt_q     <= '0;
        col_acc_q <= '0;
        mode_q    <= MODE_EVEN;
      end else begin
        cnt_q     <= last_data ? '0 : cnt_q + 1'b1;
        col_acc_q <= col_acc_q ^ bus.in_data;
        mode_q    <= mode_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_parity  <= 1'b0;
      bus.out_row_err <= 1'b0;
      bus.out_col_err <= 1'b0;
      bus.out_last    <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_data    <= bus.in_data;
      bus.out_parity  <= gen;
      bus.out_row_err <= row_err;
      bus.out_col_err <= col_err;
      bus.out_last    <= is_check;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end

  assign cnt_sum = {1'b0, err_count} + (CNT_W+1)'(row_err) + (CNT_W+1)'(col_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (accept) begin
      err_count <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Streaming, parametrised successor to the team's 8-bit even-parity checker. It checks a per-word row parity bit, selectable even or odd. It also checks a per-frame column parity (LRC) word that follows every FRAME_LEN data words. For each accepted word it regenerates the row parity bit and keeps a saturating error count. It sits between a link receiver and downstream consumers on a valid/ready stream, with a 1-cycle registered output.

Parameters:
DATA_W, 8, data word width (>=1)
FRAME_LEN, 4, data words per frame before the LRC check word (>=1)
CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
odd_mode  input  1  0=even parity, 1=odd parity; latched at frame start
abort  input  1  sync: drop current frame accumulation
clr_count  input  1  sync clear of err_count
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  DATA_W  input word (data or LRC check word)
in_parity  input  1  received row parity bit for in_data
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts the word
out_data  output  DATA_W  registered copy of in_data
out_parity  output  1  regenerated row parity of out_data (mode-correct)
out_row_err  output  1  row parity mismatch on this word
out_col_err  output  1  LRC mismatch; only ever 1 when out_last=1
out_last  output  1  this word is the frame's LRC check word
err_count  output  CNT_W  saturating count of row+col errors

Behaviour:
- Reset (rst_n=0, async): all outputs 0, err_count 0, state S_DATA, word counter 0, column accumulator 0, latched mode 0.
- Handshake: in_ready = !out_valid || out_ready, combinational. Accept means in_valid && in_ready.
- Latency is 1 cycle: an accepted word appears on the outputs next cycle.
- While out_valid && !out_ready, all out_* signals hold stable.
- out_valid drops after a consumed word when no new word is accepted.
- Row parity: gen = ^in_data ^ mode. row_err = (gen != in_parity). This applies to data words and to the check word.
- mode = odd_mode when the accepted word is the first of a frame (S_DATA, cnt=0); otherwise mode = the latched value. Changes to odd_mode mid-frame are ignored.
- FSM:
  - S_DATA: each accept does col_acc ^= in_data and cnt++. When cnt==FRAME_LEN-1 on accept, go to S_CHECK.
  - S_CHECK: the accepted word is the LRC. col_err = (in_data != col_acc) and out_last=1. Then col_acc<=0, cnt<=0, go to S_DATA.
- col_acc is always even column parity; odd_mode affects row parity only.
- FRAME_LEN=1: S_DATA always moves to S_CHECK after one word.
- abort=1: state<=S_DATA, cnt<=0, col_acc<=0 next cycle, and the latched mode is released.
  - The output register and err_count are unaffected.
  - If abort coincides with an accept, the word still passes to the output with its row check, but it does not enter the new frame's accumulation. If it was a check word, col_err is still reported.
- err_count += row_err + col_err (0..2) on each accept, saturating at 2^CNT_W-1; it never wraps. clr_count has priority: the count becomes 0 and that cycle's increment is discarded.
- Reset mid-frame discards the frame, and any word in the output register is lost.

Decomposition:
- Package parity_pkg: state enum {S_DATA, S_CHECK}; MODE_EVEN=0 and MODE_ODD=1 constants; a function for counter-width calculation (clog2 of FRAME_LEN).
- One natural sub-module, parity_reduce: combinational, DATA_W-wide XOR reduction with a mode input, giving the gen bit.

Test Plan:
- Even mode, FRAME_LEN=4, words 0x01/p1, 0x03/p0, 0x07/p1, 0x0F/p0, then LRC 0x0A/p0, out_ready=1 -> all row_err=0; fifth output has out_last=1, col_err=0; err_count=0; each output 1 cycle after accept.
- Same frame with word 2 sent as 0x03/p1 and LRC 0x0B/p1 -> row_err on word 2, col_err=1 on LRC, err_count=2.
- Odd mode: 0x00/p1 -> row_err=0, out_parity=1. Toggle odd_mode mid-frame and send 0x00/p1 -> still row_err=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no lost or duplicated words; release -> stream resumes in order.
- CNT_W=2, five consecutive bad-row words -> err_count 1,2,3,3,3. Assert clr_count together with a bad word -> err_count=0.
- Assert abort after 2 data words, then send a full good frame -> no col_err. Assert rst_n=0 mid-frame -> outputs zero immediately, async.
